// File: rtl/lcd_timing_drv.sv
// RGB-LCD timing driver: per-panel HSYNC/VSYNC/DE, pixel request and RGB forwarding.
// Define LCD_DE_ONLY_EN to tie HSYNC/VSYNC high for DE-mode panels.
module lcd_timing_drv (
  input  logic        clk_dri,
  input  logic        sys_rst_n,
  input  logic [15:0] lcd_id,
  input  logic [23:0] lcd_data,
  output logic        data_req,
  output logic [10:0] lcd_xpos,
  output logic [10:0] lcd_ypos,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic        lcd_bl,
  output logic        lcd_rst
);

  typedef struct packed {
    logic [10:0] vs;
    logic [10:0] vbp;
    logic [10:0] vd;
    logic [10:0] vsum;
    logic [10:0] hs;
    logic [10:0] hbp;
    logic [10:0] hd;
    logic [10:0] hsum;
  } timing_t;

  // Front porches are implied by the totals, so only the sums are kept.
  function automatic timing_t timing_of(input logic [15:0] id);
    timing_t t;
    case (id)
      16'h4342, 16'h4384: t = '{vs: 11'd10, vbp: 11'd2,  vd: 11'd272, vsum: 11'd286,
                                hs: 11'd41, hbp: 11'd2,  hd: 11'd480, hsum: 11'd525};
      16'h7084:           t = '{vs: 11'd2,  vbp: 11'd33, vd: 11'd480, vsum: 11'd525,
                                hs: 11'd128, hbp: 11'd88, hd: 11'd800, hsum: 11'd1056};
      16'h7016:           t = '{vs: 11'd3,  vbp: 11'd20, vd: 11'd600, vsum: 11'd635,
                                hs: 11'd20, hbp: 11'd140, hd: 11'd1024, hsum: 11'd1344};
      default:            t = '{vs: 11'd3,  vbp: 11'd10, vd: 11'd800, vsum: 11'd823,
                                hs: 11'd10, hbp: 11'd80, hd: 11'd1280, hsum: 11'd1440};
    endcase
    return t;
  endfunction

  timing_t     r_tim;
  logic        r_cfg_vld;
  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic        r_de;

  logic        w_h_last;
  logic        w_v_last;
  logic [10:0] w_v_beg;
  logic [10:0] w_v_end;
  logic [10:0] w_h_beg;
  logic [10:0] w_h_end;
  logic        w_v_act;

  assign w_h_last = (r_h_cnt == r_tim.hsum - 11'd1);
  assign w_v_last = (r_v_cnt == r_tim.vsum - 11'd1);
  assign w_v_beg  = r_tim.vs + r_tim.vbp;
  assign w_v_end  = w_v_beg + r_tim.vd - 11'd1;
  // The request window opens one pixel early so the generator's one-cycle latency lines up with DE.
  assign w_h_beg  = r_tim.hs + r_tim.hbp - 11'd1;
  assign w_h_end  = r_tim.hs + r_tim.hbp + r_tim.hd - 11'd2;
  assign w_v_act  = (r_v_cnt >= w_v_beg) && (r_v_cnt <= w_v_end);

  // NOTE: every register here, including the timing set, has a defined reset value and is
  // updated with non-blocking assignments so all state moves together on the clock edge.
  always_ff @(posedge clk_dri or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tim     <= timing_of(16'h1018);
      r_cfg_vld <= 1'b0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_de      <= 1'b0;
    end else begin
      r_de <= data_req;
      if (!r_cfg_vld) begin
        r_tim     <= timing_of(lcd_id);
        r_cfg_vld <= 1'b1;
      end else if (w_h_last) begin
        r_h_cnt <= '0;
        if (w_v_last) begin
          r_v_cnt <= '0;
          r_tim   <= timing_of(lcd_id);
        end else begin
          r_v_cnt <= r_v_cnt + 11'd1;
        end
      end else begin
        r_h_cnt <= r_h_cnt + 11'd1;
      end
    end
  end

  assign data_req = w_v_act && (r_h_cnt >= w_h_beg) && (r_h_cnt <= w_h_end);
  assign lcd_xpos = r_h_cnt;
  assign lcd_ypos = r_v_cnt;
  assign lcd_de   = r_de;
  assign lcd_rgb  = r_de ? lcd_data : 24'd0;
  assign lcd_bl   = r_cfg_vld;
  assign lcd_rst  = r_cfg_vld;

`ifdef LCD_DE_ONLY_EN
  assign lcd_hs = 1'b1;
  assign lcd_vs = 1'b1;
`else
  assign lcd_hs = !(r_h_cnt < r_tim.hs);
  assign lcd_vs = !(r_v_cnt < r_tim.vs);
`endif

endmodule
